// File: rtl/slowfil_sequencer.sv
// Sequencer in front of the slow symmetric FIR: coefficient reload, sample pacing with a
// guaranteed idle gap between filter strobes, and a valid/ready result register.
module slowfil_sequencer #(
   parameter int unsigned IW           = 16,
   parameter int unsigned TW           = 12,
   parameter int unsigned OW           = 35,
   parameter int unsigned LGNCOEF      = 6,
   parameter int unsigned NCOEF        = 53,
   parameter int unsigned MINGAP       = 107,
   parameter logic        START_LOADED = 1'b0
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_reload,
   input  logic          s_tap_valid,
   output logic          s_tap_ready,
   input  logic [TW-1:0] s_tap_data,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [IW-1:0] s_data,
   output logic          o_fil_reset,
   output logic          o_tap_wr,
   output logic [TW-1:0] o_tap,
   output logic          o_fil_ce,
   output logic [IW-1:0] o_fil_sample,
   input  logic          i_fil_ce,
   input  logic [OW-1:0] i_fil_result,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [OW-1:0] m_data,
   output logic          o_loaded,
   output logic          o_overrun
);

   typedef enum logic [2:0] {StWait, StRun, StDrain, StClr, StLoad} state_e;

   localparam state_e        StReset  = START_LOADED ? StRun : StWait;
   localparam logic [7:0]    GapInit  = 8'(MINGAP);
   localparam logic [LGNCOEF-1:0] LastCoef = LGNCOEF'(NCOEF - 1);

   state_e               state_q, state_d;
   logic [7:0]           gap_q, gap_d;
   logic [LGNCOEF-1:0]   cnt_q, cnt_d;
   logic                 tap_wr_q;
   logic [TW-1:0]        tap_q;
   logic                 fil_ce_q;
   logic [IW-1:0]        fil_sample_q;
   logic                 m_valid_q, m_valid_d;
   logic [OW-1:0]        m_data_q, m_data_d;
   logic                 overrun_q, overrun_d;
   logic                 tap_hs, smp_hs, res_hs;

   assign s_tap_ready = (state_q == StLoad);
   assign s_ready     = (state_q == StRun) && (gap_q == 8'd0);
   assign o_fil_reset = (state_q == StClr);
   assign o_loaded    = (state_q == StRun) || (state_q == StDrain);

   assign tap_hs = s_tap_ready && s_tap_valid;
   assign smp_hs = s_ready && s_valid;
   // Results arriving while the filter is being cleared or reloaded are stale.
   assign res_hs = i_fil_ce && o_loaded;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      overrun_d = overrun_q;

      unique case (state_q)
         StWait:  if (i_reload) state_d = StClr;
         StRun:   if (i_reload) state_d = StDrain;
         StDrain: if (gap_q == 8'd0) state_d = StClr;
         StClr: begin
            cnt_d   = '0;
            state_d = StLoad;
         end
         StLoad: begin
            if (tap_hs) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LastCoef) state_d = StRun;
            end
         end
         default: state_d = StReset;
      endcase

      // The gap keeps counting through a reload so pacing spans it.
      if (smp_hs) gap_d = GapInit;
      else if (gap_q != 8'd0) gap_d = gap_q - 8'd1;

      if (res_hs) begin
         m_valid_d = 1'b1;
         m_data_d  = i_fil_result;
         if (m_valid_q && !m_ready) overrun_d = 1'b1;
      end else if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end
      if (state_q == StClr) overrun_d = 1'b0;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= StReset;
         gap_q        <= '0;
         cnt_q        <= '0;
         tap_wr_q     <= 1'b0;
         tap_q        <= '0;
         fil_ce_q     <= 1'b0;
         fil_sample_q <= '0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         overrun_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_q     <= gap_d;
         cnt_q     <= cnt_d;
         tap_wr_q  <= tap_hs;
         fil_ce_q  <= smp_hs;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         overrun_q <= overrun_d;
         if (tap_hs) tap_q <= s_tap_data;
         if (smp_hs) fil_sample_q <= s_data;
      end
   end

   assign o_tap_wr     = tap_wr_q;
   assign o_tap        = tap_q;
   assign o_fil_ce     = fil_ce_q;
   assign o_fil_sample = fil_sample_q;
   assign m_valid      = m_valid_q;
   assign m_data       = m_data_q;
   assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_slowfil_sequencer.sv
// Directed bench for slowfil_sequencer; the filter is modelled by driving i_fil_ce/result.
module tb_slowfil_sequencer;

   logic          i_clk = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_reload = 1'b0;
   logic          s_tap_valid = 1'b0;
   logic          s_tap_ready;
   logic [11:0]   s_tap_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [15:0]   s_data = 16'h0100;
   logic          o_fil_reset, o_tap_wr, o_fil_ce;
   logic [11:0]   o_tap;
   logic [15:0]   o_fil_sample;
   logic          i_fil_ce = 1'b0;
   logic [34:0]   i_fil_result = '0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [34:0]   m_data;
   logic          o_loaded, o_overrun;

   slowfil_sequencer dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_reload(i_reload),
      .s_tap_valid(s_tap_valid), .s_tap_ready(s_tap_ready), .s_tap_data(s_tap_data),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .o_fil_reset(o_fil_reset), .o_tap_wr(o_tap_wr), .o_tap(o_tap),
      .o_fil_ce(o_fil_ce), .o_fil_sample(o_fil_sample),
      .i_fil_ce(i_fil_ce), .i_fil_result(i_fil_result),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .o_loaded(o_loaded), .o_overrun(o_overrun)
   );

   always #5 i_clk = ~i_clk;

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;
   int clr_cnt = 0;
   int clr_cyc = 0;
   int rdy_cnt = 0;
   logic [11:0] wr_q[$];
   int          ce_cyc[$];
   logic [15:0] ce_smp[$];

   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) begin
      if (o_tap_wr) wr_q.push_back(o_tap);
      if (o_fil_ce) begin
         ce_cyc.push_back(cyc);
         ce_smp.push_back(o_fil_sample);
      end
      if (o_fil_reset) begin
         clr_cnt++;
         clr_cyc = cyc;
      end
      if (s_ready) rdy_cnt++;
   end

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reload();
      int i;
      i_reload = 1'b1;
      tick();
      i_reload = 1'b0;
      i = 0;
      while (!o_fil_reset && i < 300) begin
         tick();
         i++;
      end
      if (!o_fil_reset) chk_eq("clr_timeout", 64'd0, 64'd1);
   endtask

   task automatic load_taps(input int n, input bit toggle, input bit pulses);
      int  k = 0;
      int  i = 0;
      bit  vld, rdy;
      while (k < n && i < 2000) begin
         vld         = !toggle || (i % 2 == 0);
         s_tap_valid = vld;
         s_tap_data  = 12'(k + 1);
         i_reload    = pulses && (i % 7 == 3);
         rdy         = s_tap_ready;
         tick();
         if (vld && rdy) k++;
         i++;
      end
      s_tap_valid = 1'b0;
      i_reload    = 1'b0;
      if (k < n) chk_eq("load_timeout", 64'(k), 64'(n));
   endtask

   task automatic check_writes(input string tag);
      repeat (2) tick();
      chk_eq({tag, "_nwr"}, 64'(wr_q.size()), 64'd53);
      for (int j = 0; j < wr_q.size() && j < 53; j++)
         chk_eq({tag, "_tap"}, 64'(wr_q[j]), 64'(j + 1));
      chk_eq({tag, "_loaded"}, 64'(o_loaded), 64'd1);
      wr_q.delete();
   endtask

   task automatic send_samples(input int n);
      int got = 0;
      int i = 0;
      bit rdy;
      s_valid = 1'b1;
      while (got < n && i < 200 * n) begin
         rdy = s_ready;
         tick();
         if (rdy) begin
            got++;
            s_data = s_data + 16'd1;
         end
         i++;
      end
      s_valid = 1'b0;
      if (got < n) chk_eq("samp_timeout", 64'(got), 64'(n));
   endtask

   initial begin
      int last_ce;
      // Reset values
      #1;
      chk_eq("rst_loaded", 64'(o_loaded), 64'd0);
      chk_eq("rst_s_ready", 64'(s_ready), 64'd0);
      chk_eq("rst_tap_ready", 64'(s_tap_ready), 64'd0);
      chk_eq("rst_m_valid", 64'(m_valid), 64'd0);
      chk_eq("rst_fil_reset", 64'(o_fil_reset), 64'd0);
      chk_eq("rst_m_data", 64'(m_data), 64'd0);
      repeat (3) tick();
      i_reset = 1'b0;
      tick();
      chk_eq("wait_idle", 64'(o_loaded), 64'd0);

      // Initial load, no bubbles
      do_reload();
      chk_eq("clr_tap_ready", 64'(s_tap_ready), 64'd0);
      load_taps(53, 1'b0, 1'b0);
      chk_eq("last_wr_in_run", 64'(o_tap_wr && o_loaded), 64'd1);
      check_writes("load1");
      chk_eq("clr_once", 64'(clr_cnt), 64'd1);

      // Pacing: 108 cycles between strobes, samples in order
      ce_cyc.delete();
      ce_smp.delete();
      send_samples(3);
      tick();
      chk_eq("pace_n", 64'(ce_cyc.size()), 64'd3);
      if (ce_cyc.size() == 3) begin
         chk_eq("pace_d1", 64'(ce_cyc[1] - ce_cyc[0]), 64'd108);
         chk_eq("pace_d2", 64'(ce_cyc[2] - ce_cyc[1]), 64'd108);
         for (int j = 0; j < 3; j++)
            chk_eq("pace_smp", 64'(ce_smp[j]), 64'(16'h0100 + j));
      end

      // Reload 5 cycles after a sample: drain waits out the gap
      repeat (4) tick();
      last_ce = ce_cyc[$];
      rdy_cnt = 0;
      s_valid = 1'b1;
      do_reload();
      s_valid = 1'b0;
      chk_eq("drain_no_ready", 64'(rdy_cnt), 64'd0);
      chk_eq("drain_gap", 64'((o_fil_reset && (cyc - last_ce) >= 108) ? 1 : 0), 64'd1);
      load_taps(53, 1'b0, 1'b0);
      check_writes("load2");
      send_samples(1);
      tick();
      chk_eq("resume_gap", 64'(((ce_cyc[$] - last_ce) >= 108) ? 1 : 0), 64'd1);
      chk_eq("resume_smp", 64'(ce_smp[$]), 64'h0103);

      // Result capture and overrun
      m_ready = 1'b0;
      i_fil_ce = 1'b1;
      i_fil_result = 35'h1_2345_6789;
      tick();
      i_fil_ce = 1'b0;
      chk_eq("res1_valid", 64'(m_valid), 64'd1);
      chk_eq("res1_data", 64'(m_data), 64'h1_2345_6789);
      chk_eq("res1_ovr", 64'(o_overrun), 64'd0);
      i_fil_ce = 1'b1;
      i_fil_result = 35'h7_0000_0abc;
      tick();
      i_fil_ce = 1'b0;
      chk_eq("res2_data", 64'(m_data), 64'h7_0000_0abc);
      chk_eq("res2_ovr", 64'(o_overrun), 64'd1);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk_eq("res_drained", 64'(m_valid), 64'd0);
      chk_eq("ovr_sticky", 64'(o_overrun), 64'd1);
      do_reload();
      tick();
      chk_eq("ovr_cleared", 64'(o_overrun), 64'd0);
      i_fil_ce = 1'b1;
      i_fil_result = 35'h5_5555_5555;
      tick();
      i_fil_ce = 1'b0;
      chk_eq("res_ign_load", 64'(m_valid), 64'd0);
      load_taps(53, 1'b0, 1'b0);
      check_writes("load3");
      i_fil_ce = 1'b1;
      i_fil_result = 35'h0_0000_0011;
      tick();
      m_ready = 1'b1;
      i_fil_result = 35'h0_0000_0022;
      tick();
      i_fil_ce = 1'b0;
      m_ready = 1'b0;
      chk_eq("rdy_ce_valid", 64'(m_valid), 64'd1);
      chk_eq("rdy_ce_data", 64'(m_data), 64'h22);
      chk_eq("rdy_ce_ovr", 64'(o_overrun), 64'd0);

      // Reset mid-load
      do_reload();
      load_taps(20, 1'b0, 1'b0);
      i_reset = 1'b1;
      #1;
      chk_eq("arst_tap_wr", 64'(o_tap_wr), 64'd0);
      chk_eq("arst_tap_ready", 64'(s_tap_ready), 64'd0);
      chk_eq("arst_loaded", 64'(o_loaded), 64'd0);
      chk_eq("arst_m_valid", 64'(m_valid), 64'd0);
      chk_eq("arst_m_data", 64'(m_data), 64'd0);
      wr_q.delete();
      s_tap_valid = 1'b1;
      repeat (3) tick();
      s_tap_valid = 1'b0;
      i_reset = 1'b0;
      tick();
      chk_eq("arst_no_wr", 64'(wr_q.size()), 64'd0);
      do_reload();
      load_taps(53, 1'b0, 1'b0);
      check_writes("load4");

      // Bubbled load with ignored reload pulses
      clr_cnt = 0;
      do_reload();
      load_taps(53, 1'b1, 1'b1);
      check_writes("load5");
      chk_eq("pulse_ignored", 64'(clr_cnt), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
